mac_array_ctrl: RTL and testbench

- Sequencer for the row x col systolic MAC-tile array.
- On a start pulse it runs one pass: reads `col` weight words from SRAM and drives kernel-load instructions, then streams `num_vec` activation vectors under execute, drains the array, and pulses done.
- Generates the SRAM read address/enable and per-row 2-bit instructions {execute, kernel_load}, skewed one cycle per row to match the array wavefront.

---
 rtl/mac_array_ctrl_if.sv | 37 +++
 rtl/mac_array_ctrl.sv | 118 +++++++++++
 tb/tb_mac_array_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mac_array_ctrl_if.sv
// Command/status bundle between the MAC-array sequencer and its host/SRAM/array side.
// PERF_CNT_EN adds the perf_cycles status field.
interface mac_array_ctrl_if #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 8
);
    logic                 start;
    logic [len_bw-1:0]    num_vec;
    logic [addr_bw-1:0]   w_base;
    logic [addr_bw-1:0]   x_base;
    logic                 sram_cen;
    logic [addr_bw-1:0]   sram_addr;
    logic [2*row-1:0]     inst_w;
    logic                 busy;
    logic                 done;
`ifdef PERF_CNT_EN
    logic [15:0]          perf_cycles;
`endif

    modport master (
`ifdef PERF_CNT_EN
        input  perf_cycles,
`endif
        output start, num_vec, w_base, x_base,
        input  sram_cen, sram_addr, inst_w, busy, done
    );

    modport slave (
`ifdef PERF_CNT_EN
        output perf_cycles,
`endif
        input  start, num_vec, w_base, x_base,
        output sram_cen, sram_addr, inst_w, busy, done
    );
endinterface

// File: rtl/mac_array_ctrl.sv
// Systolic MAC-tile array sequencer: weight load, activation stream, drain, done.
// Define PERF_CNT_EN to add the per-pass busy-cycle counter (perf_cycles).
module mac_array_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int len_bw  = 8
) (
    input  logic             clk,
    input  logic             reset,
    mac_array_ctrl_if.slave  bus
);
    localparam int CNT_MIN = $clog2(row + col + 2);
    localparam int CNT_BW  = (len_bw > CNT_MIN) ? len_bw : CNT_MIN;

    typedef enum logic [2:0] {IDLE, KLOAD, EXEC, DRAIN, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_BW-1:0]    cnt, cnt_nxt;
    logic [addr_bw-1:0]   addr_q, addr_nxt;
    logic [len_bw-1:0]    nv_q;
    logic [addr_bw-1:0]   xb_q;
    logic                 latch;
    logic                 cen_q, busy_q, done_q;
    logic [1:0]           inst0;
    logic [row-1:0][1:0]  inst_pipe;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        latch     = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_nxt = KLOAD;
                cnt_nxt   = '0;
                addr_nxt  = bus.w_base;
                latch     = 1'b1;
            end
            KLOAD: if (cnt == CNT_BW'(col - 1)) begin
                cnt_nxt = '0;
                if (nv_q == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = EXEC;
                    addr_nxt  = xb_q;
                end
            end else begin
                cnt_nxt  = cnt + CNT_BW'(1);
                addr_nxt = addr_q + addr_bw'(1);
            end
            EXEC: if (cnt + CNT_BW'(1) == CNT_BW'(nv_q)) begin
                state_nxt = DRAIN;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt  = cnt + CNT_BW'(1);
                addr_nxt = addr_q + addr_bw'(1);
            end
            // Long enough for the last execute to ripple down every row and out of every column.
            DRAIN: if (cnt == CNT_BW'(row + col)) begin
                state_nxt = DONE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + CNT_BW'(1);
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // SRAM data arrives one cycle after the read, so row 0 follows the current state.
    assign inst0 = {state == EXEC, state == KLOAD};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            nv_q      <= '0;
            xb_q      <= '0;
            cen_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            inst_pipe <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            addr_q <= addr_nxt;
            if (latch) begin
                nv_q <= bus.num_vec;
                xb_q <= bus.x_base;
            end
            cen_q  <= !(state_nxt == KLOAD || state_nxt == EXEC);
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == DONE);
            for (int r = row - 1; r > 0; r--) inst_pipe[r] <= inst_pipe[r-1];
            inst_pipe[0] <= inst0;
        end
    end

    assign bus.sram_cen  = cen_q;
    assign bus.sram_addr = addr_q;
    assign bus.inst_w    = inst_pipe;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef PERF_CNT_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (!reset)                        perf_q <= '0;
        else if (latch)                    perf_q <= '0;
        else if (busy_q && perf_q != '1)   perf_q <= perf_q + 16'd1;
    end

    assign bus.perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_mac_array_ctrl.sv
// Scoreboard bench for mac_array_ctrl: per-pass expectations come from a cycle-level
// timeline model; a negedge monitor pops/compares SRAM reads, done pulses, busy and inst_w.
module tb_mac_array_ctrl;
    localparam int ROW = 8, COL = 8, ABW = 11, LBW = 8;
    localparam int AMOD = 1 << ABW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;

    mac_array_ctrl_if #(.row(ROW), .col(COL), .addr_bw(ABW), .len_bw(LBW)) bus();

    mac_array_ctrl #(.row(ROW), .col(COL), .addr_bw(ABW), .len_bw(LBW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int t; int a; } rd_t;
    rd_t              rd_q[$];
    int               done_q[$];
    logic [2*ROW-1:0] inst_map[int];
    bit               busy_map[int];

    int checks = 0;
    int passed = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endfunction

    function automatic void add_inst(input int t, input int r, input bit exe);
        logic [2*ROW-1:0] v;
        v = '0;
        v[2*r + (exe ? 1 : 0)] = 1'b1;
        if (inst_map.exists(t)) inst_map[t] = inst_map[t] | v;
        else                    inst_map[t] = v;
    endfunction

    // Start sampled at the edge ending cycle c; pass cycle n is absolute cycle c+n.
    function automatic void model_pass(input int c, input int nv, input int wb, input int xb,
                                       output int drel);
        for (int k = 0; k < COL; k++) rd_q.push_back('{c + 1 + k, (wb + k) % AMOD});
        for (int v = 0; v < nv; v++)  rd_q.push_back('{c + 1 + COL + v, (xb + v) % AMOD});
        drel = (nv > 0) ? 2*COL + nv + ROW + 2 : COL + 1;
        done_q.push_back(c + drel);
        for (int n = 1; n <= drel; n++) busy_map[c + n] = 1'b1;
        for (int r = 0; r < ROW; r++) begin
            for (int n = 2; n <= COL + 1; n++)            add_inst(c + n + r, r, 1'b0);
            for (int n = COL + 2; n <= COL + nv + 1; n++) add_inst(c + n + r, r, 1'b1);
        end
    endfunction

    function automatic void abort_after(input int t);
        int keys[$];
        while (rd_q.size() > 0 && rd_q[$].t > t) void'(rd_q.pop_back());
        while (done_q.size() > 0 && done_q[$] > t) void'(done_q.pop_back());
        foreach (inst_map[k]) if (k > t) keys.push_back(k);
        foreach (keys[i]) inst_map.delete(keys[i]);
        keys.delete();
        foreach (busy_map[k]) if (k > t) keys.push_back(k);
        foreach (keys[i]) busy_map.delete(keys[i]);
    endfunction

    always @(negedge clk) begin : mon
        bit er, ed;
        if (cyc >= 1) begin
            er = rd_q.size() > 0 && rd_q[0].t == cyc;
            chk("sram_cen", bus.sram_cen, !er);
            if (er) begin
                if (bus.sram_cen == 1'b0) chk("sram_addr", bus.sram_addr, rd_q[0].a);
                void'(rd_q.pop_front());
            end
            ed = done_q.size() > 0 && done_q[0] == cyc;
            chk("done", bus.done, ed);
            if (ed) void'(done_q.pop_front());
            chk("busy", bus.busy, busy_map.exists(cyc));
            chk("inst_w", bus.inst_w, inst_map.exists(cyc) ? inst_map[cyc] : '0);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic run_pass(input int nv, input int wb, input int xb, input bit hold);
        int c, drel;
        c = cyc;
        bus.start   = 1'b1;
        bus.num_vec = LBW'(nv);
        bus.w_base  = ABW'(wb);
        bus.x_base  = ABW'(xb);
        model_pass(c, nv, wb, xb, drel);
        step();
        if (!hold) bus.start = 1'b0;
        bus.num_vec = LBW'($urandom);
        bus.w_base  = ABW'($urandom);
        bus.x_base  = ABW'($urandom);
        while (cyc < c + drel + 1) step();
`ifdef PERF_CNT_EN
        chk("perf_cycles", bus.perf_cycles, drel);
`endif
    endtask

    initial begin
        int c, nv, sel;
        bit hold;
        bus.start = 1'b0; bus.num_vec = '0; bus.w_base = '0; bus.x_base = '0;
        repeat (3) step();
        chk("reset_addr", bus.sram_addr, 0);
        reset = 1'b1;
        repeat (4) step();

        run_pass(16, 'h010, 'h100, 1'b0);
        repeat (2) step();
        run_pass(0, 'h020, 'h200, 1'b0);
        run_pass(3, 'h030, 'h300, 1'b0);
        repeat (3) step();
        run_pass(2, 'h040, 'h400, 1'b1);
        run_pass(2, 'h050, 'h500, 1'b1);
        bus.start = 1'b0;
        repeat (2) step();
        run_pass(5, 2046, 2040, 1'b0);
        repeat (2) step();

        // Abort in EXEC cycle 12 of a nominal pass.
        c = cyc;
        bus.start = 1'b1; bus.num_vec = 8'd16; bus.w_base = 11'h010; bus.x_base = 11'h100;
        model_pass(c, 16, 'h010, 'h100, nv);
        step();
        bus.start = 1'b0;
        while (cyc < c + 12) step();
        reset = 1'b0;
        abort_after(c + 12);
        step();
        chk("abort_addr", bus.sram_addr, 0);
        step();
        reset = 1'b1;
        repeat (2) step();
        run_pass(16, 'h010, 'h100, 1'b0);

        for (int i = 0; i < 20; i++) begin
            sel  = $urandom_range(0, 9);
            nv   = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(200, 255) : $urandom_range(1, 20);
            hold = 1'($urandom_range(0, 1));
            run_pass(nv, $urandom_range(0, AMOD-1), $urandom_range(0, AMOD-1), hold);
            if (!hold || $urandom_range(0, 1) == 0) begin
                bus.start = 1'b0;
                repeat ($urandom_range(0, 4)) step();
            end
        end
        bus.start = 1'b0;
        repeat (ROW + 4) step();
        chk("reads_drained", rd_q.size(), 0);
        chk("dones_drained", done_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
